// File: rtl/stack_test_ctrl.sv
// Sequences a stacked self-test: strap a base layer, wait for every chip's sort, validate IDs, stream records.
// Latency: start to done = 1 (arm) + W (sort wait) + N_CHIP (check) + N_CHIP (readout, rd_ready high) + 1.
// Backpressure: the rd_* record port holds all outputs while rd_ready is low; nothing is skipped or repeated.
//
// Ports: t_clk/rst_n clock and async active-low reset; start/bottom_sel begin a run from IDLE;
// f_layer one-hot strap to the chips; sort_finish/chip_id/power_value_* per-chip inputs (chip i at [i*W +: W]);
// busy/done/timeout_err/id_err/pwr_sum run status; rd_valid/rd_ready/rd_index/rd_chip_id/rd_pwr record stream.
module stack_test_ctrl #(
  parameter int N_CHIP  = 8,
  parameter int ID_W    = 4,
  parameter int PWR_W   = 4,
  parameter int TIMEOUT = 255,
  parameter int SEL_W   = 3
) (
  input  logic                      t_clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [SEL_W-1:0]          bottom_sel,
  output logic [N_CHIP-1:0]         f_layer,
  input  logic [N_CHIP-1:0]         sort_finish,
  input  logic [N_CHIP*ID_W-1:0]    chip_id,
  input  logic [N_CHIP*PWR_W-1:0]   power_value_upper,
  input  logic [N_CHIP*PWR_W-1:0]   power_value_lower,
  output logic                      busy,
  output logic                      done,
  output logic                      timeout_err,
  output logic                      id_err,
  output logic [2*PWR_W+SEL_W-1:0]  pwr_sum,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [SEL_W-1:0]          rd_index,
  output logic [ID_W-1:0]           rd_chip_id,
  output logic [2*PWR_W-1:0]        rd_pwr
);

  localparam int                SUM_W = 2*PWR_W + SEL_W;
  localparam int                CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  TO_VAL = CNT_W'(TIMEOUT);
  localparam logic [SEL_W-1:0]  LAST_IDX = SEL_W'(N_CHIP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_WAIT_SORT, S_CHECK, S_READOUT, S_DONE
  } state_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt;
  logic [SEL_W-1:0]     chk_idx;
  logic [N_CHIP-1:0]    seen;
  logic [ID_W-1:0]      snap_id  [N_CHIP];
  logic [2*PWR_W-1:0]   snap_pwr [N_CHIP];

  logic                 start_ok;
  logic                 all_sorted;
  logic [ID_W-1:0]      cur_id;
  logic [2*PWR_W-1:0]   cur_pwr;
  logic                 id_in_range;
  logic                 id_bad;

  assign start_ok    = start && (32'(bottom_sel) < N_CHIP);
  assign all_sorted  = &sort_finish;
  assign cur_id      = chip_id[chk_idx*ID_W +: ID_W];
  assign cur_pwr     = {power_value_upper[chk_idx*PWR_W +: PWR_W],
                        power_value_lower[chk_idx*PWR_W +: PWR_W]};
  assign id_in_range = 32'(cur_id) < N_CHIP;
  // Out-of-range IDs never index the seen-mask; they are flagged on range alone.
  assign id_bad      = !id_in_range || seen[cur_id[SEL_W-1:0]];

  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign rd_valid   = (state == S_READOUT);
  assign rd_chip_id = snap_id[rd_index];
  assign rd_pwr     = snap_pwr[rd_index];

  always_ff @(posedge t_clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:      if (start_ok) state_n = S_ARM;
      S_ARM:       state_n = S_WAIT_SORT;
      // Finishing is tested first so it wins over a coincident timeout.
      S_WAIT_SORT: if (all_sorted)          state_n = S_CHECK;
                   else if (cnt == TO_VAL)  state_n = S_DONE;
      S_CHECK:     if (chk_idx == LAST_IDX) state_n = S_READOUT;
      S_READOUT:   if (rd_ready && rd_index == LAST_IDX) state_n = S_DONE;
      S_DONE:      state_n = S_IDLE;
      default:     state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge t_clk or negedge rst_n) begin
    if (!rst_n) begin
      f_layer     <= '0;
      cnt         <= '0;
      chk_idx     <= '0;
      rd_index    <= '0;
      seen        <= '0;
      timeout_err <= 1'b0;
      id_err      <= 1'b0;
      pwr_sum     <= '0;
      for (int i = 0; i < N_CHIP; i++) begin
        snap_id[i]  <= '0;
        snap_pwr[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            timeout_err <= 1'b0;
            id_err      <= 1'b0;
            pwr_sum     <= '0;
            seen        <= '0;
          end
        end
        S_ARM: begin
          f_layer <= {{(N_CHIP-1){1'b0}}, 1'b1} << bottom_sel;
          cnt     <= '0;
          chk_idx <= '0;
        end
        S_WAIT_SORT: begin
          cnt <= cnt + CNT_W'(1);
          if (all_sorted)          chk_idx <= '0;
          else if (cnt == TO_VAL)  timeout_err <= 1'b1;
        end
        S_CHECK: begin
          snap_id[chk_idx]  <= cur_id;
          snap_pwr[chk_idx] <= cur_pwr;
          pwr_sum           <= pwr_sum + SUM_W'(cur_pwr);
          if (id_bad)      id_err <= 1'b1;
          if (id_in_range) seen[cur_id[SEL_W-1:0]] <= 1'b1;
          chk_idx <= chk_idx + SEL_W'(1);
          if (chk_idx == LAST_IDX) rd_index <= '0;
        end
        S_READOUT: begin
          if (rd_ready) rd_index <= rd_index + SEL_W'(1);
        end
        S_DONE: begin
          // The strap is released as the sequencer returns to IDLE.
          f_layer <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/stack_test_ctrl.md
Name: stack_test_ctrl

Overview:
Sequencer for the eight-chip stacked self-test chain. It straps the chosen base layer through f_layer and waits for every chip's sort_finish, with a timeout. It then snapshots and validates the assigned chip IDs and power nibbles, accumulates total stack power, and streams one record per chip to the tester over a valid/ready port. It sits above the chip chain on the same t_clk.

Parameters:
N_CHIP, 8, number of stacked chips; also the number of records streamed
ID_W, 4, chip_id width per chip
PWR_W, 4, width of each power nibble (upper and lower)
TIMEOUT, 255, maximum WAIT_SORT cycles before abort
SEL_W, 3, width of bottom_sel, equal to clog2(N_CHIP)

Ports:
t_clk  in  1  single clock; all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
start  in  1  begin a test run; sampled only in IDLE
bottom_sel  in  SEL_W  index of the chip strapped as first layer
f_layer  out  N_CHIP  one-hot first-layer strap, bit i goes to chip i
sort_finish  in  N_CHIP  per-chip ID sort complete flags
chip_id  in  N_CHIP*ID_W  packed IDs; chip i occupies bits [i*ID_W +: ID_W]
power_value_upper  in  N_CHIP*PWR_W  packed upper nibbles, same packing as chip_id
power_value_lower  in  N_CHIP*PWR_W  packed lower nibbles, same packing as chip_id
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of run
timeout_err  out  1  sticky; set when WAIT_SORT aborts
id_err  out  1  sticky; set on a duplicate or out-of-range ID
pwr_sum  out  2*PWR_W+SEL_W  sum of all 8-bit chip power values
rd_valid  out  1  record available
rd_ready  in  1  tester accepts the record
rd_index  out  SEL_W  chip index of the current record
rd_chip_id  out  ID_W  captured ID
rd_pwr  out  2*PWR_W  captured power, formed as {upper,lower}

Behaviour:
- Reset (asynchronous, any state): state = IDLE.
- Reset clears f_layer, busy, done, timeout_err, id_err, pwr_sum, rd_valid and rd_index to 0, plus all internal counters, the seen-mask and the snapshot buffer.
- IDLE:
  - If start=1 and bottom_sel < N_CHIP, go to ARM and clear timeout_err, id_err and pwr_sum.
  - If bottom_sel >= N_CHIP, start is ignored.
  - If start is asserted in any state other than IDLE, it is ignored.
- ARM (1 cycle): register f_layer = 1<<bottom_sel; clear the timeout counter; go to WAIT_SORT.
  - f_layer holds that value until the cycle the FSM enters IDLE.
- WAIT_SORT: the counter increments every cycle.
  - If sort_finish is all ones, go to CHECK with chk_idx = 0. If this coincides with counter == TIMEOUT, finishing wins.
  - Else if counter == TIMEOUT, set timeout_err and go to DONE. No readout occurs.
  - Latency: the abort takes effect TIMEOUT+1 cycles after WAIT_SORT entry.
- CHECK (N_CHIP cycles, one chip per cycle, index chk_idx):
  - Capture chip_id and both power nibbles of chip chk_idx into the snapshot buffer.
  - Add {upper,lower} to pwr_sum. Width is 2*PWR_W+SEL_W, so the sum of N_CHIP values cannot overflow.
  - If ID >= N_CHIP, or seen[ID] is already set, set id_err; then set seen[ID].
  - sort_finish changes during CHECK are ignored.
  - After chk_idx = N_CHIP-1, go to READOUT with rd_index = 0. The seen-mask is cleared on entry to ARM.
- READOUT: rd_valid=1. rd_chip_id and rd_pwr come from the snapshot entry selected by rd_index.
  - While rd_ready=0, all rd_* outputs hold stable.
  - On rd_valid & rd_ready, rd_index increments.
  - When the handshake completes on rd_index = N_CHIP-1, deassert rd_valid and go to DONE.
  - Records are streamed even when id_err is set.
- DONE (1 cycle): done=1; go to IDLE.
  - timeout_err, id_err and pwr_sum persist until the next accepted start.
- Nominal run latency with rd_ready held high: start to done pulse = 1 (ARM) + W + N_CHIP + N_CHIP + 1 cycles, where W is the number of WAIT_SORT cycles.

Test Plan:
- Nominal run: bottom_sel=0; sort_finish=8'hFF 3 cycles after ARM; IDs 0..7; every chip upper=4'h1, lower=4'h2; rd_ready=1. Required: f_layer=8'h01; 8 records with rd_index 0..7, rd_pwr=8'h12; pwr_sum=144; id_err=0; one done pulse.
- Timeout: TIMEOUT=15 with sort_finish=8'h7F held. Required: timeout_err=1 and done pulse 16 cycles after WAIT_SORT entry; rd_valid never asserts; f_layer returns to 0 in IDLE.
- ID errors: chips 2 and 5 both report ID 3, and chip 7 reports ID 9. Required: id_err=1; all 8 records still streamed, with rd_chip_id matching the inputs captured during CHECK.
- Backpressure: toggle rd_ready 1,0,0,1 during READOUT. Required: rd_index and data hold stable while rd_ready=0; no record is skipped or duplicated.
- Mid-run reset and start while busy: pulse start during WAIT_SORT, then assert rst_n=0 during READOUT. Required: the second start has no effect; after reset all outputs are 0 and a fresh run with bottom_sel=5 gives f_layer=8'h20.
- Coincident finish and timeout: sort_finish reaches 8'hFF on the cycle the counter equals TIMEOUT. Required: FSM enters CHECK and timeout_err=0.
